// File: rtl/ps2_key_decoder.sv
// Receive-only PS/2 keyboard front end: sync, clock glitch filter, 11-bit deframer, set-2 make/break decoder.
// Optional feature macro: PS2_ARROWS_EN (E0-prefixed left/right arrows also drive aPressed/dPressed).
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       aPressed,
  output logic       dPressed,
  output logic       spacePressed,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_STOP} state_t;

  logic [1:0]  clk_sync, dat_sync;
  logic        filt, filt_d;
  logic [4:0]  filt_cnt;
  logic        fe, dat_bit;

  state_t      state;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        par_bit;
  logic [16:0] tmo_cnt;
  logic        brk, ext;
  logic        a_key, d_key, sp_key;
`ifdef PS2_ARROWS_EN
  logic        a_arr, d_arr;
`endif

  // Synchronizers idle high so reset never looks like a falling edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt     <= 1'b1;
      filt_d   <= 1'b1;
      filt_cnt <= '0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      filt_d   <= filt;
      if (clk_sync[1] == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == 5'(FILTER_LEN - 1)) begin
        filt     <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 5'd1;
      end
    end
  end

  assign fe      = filt_d & ~filt;
  assign dat_bit = dat_sync[1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tmo_cnt    <= '0;
      brk        <= 1'b0;
      ext        <= 1'b0;
      a_key      <= 1'b0;
      d_key      <= 1'b0;
      sp_key     <= 1'b0;
`ifdef PS2_ARROWS_EN
      a_arr      <= 1'b0;
      d_arr      <= 1'b0;
`endif
      scan_code  <= '0;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fe) begin
        tmo_cnt <= '0;
        case (state)
          S_IDLE: if (!dat_bit) begin
            state   <= S_DATA;
            bit_cnt <= '0;
          end
          S_DATA: begin
            shreg   <= {dat_bit, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_PAR;
          end
          S_PAR: begin
            par_bit <= dat_bit;
            state   <= S_STOP;
          end
          default: begin
            state <= S_IDLE;
            if (dat_bit && (^{shreg, par_bit})) begin
              scan_code  <= shreg;
              scan_valid <= 1'b1;
              if (shreg == 8'hF0) begin
                brk <= 1'b1;
              end else if (shreg == 8'hE0) begin
                ext <= 1'b1;
              end else begin
                brk <= 1'b0;
                ext <= 1'b0;
                if (!ext)
                  case (shreg)
                    8'h1C:   a_key  <= ~brk;
                    8'h23:   d_key  <= ~brk;
                    8'h29:   sp_key <= ~brk;
                    default: ;
                  endcase
`ifdef PS2_ARROWS_EN
                else
                  case (shreg)
                    8'h6B:   a_arr <= ~brk;
                    8'h74:   d_arr <= ~brk;
                    default: ;
                  endcase
`endif
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
        endcase
      end else if (state != S_IDLE) begin
        // Stalled keyboard: drop the partial byte silently and resync on the next start bit.
        if (tmo_cnt == 17'(TIMEOUT_CYCLES - 1)) begin
          state   <= S_IDLE;
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 17'd1;
        end
      end
    end
  end

`ifdef PS2_ARROWS_EN
  assign aPressed = a_key | a_arr;
  assign dPressed = d_key | d_arr;
`else
  assign aPressed = a_key;
  assign dPressed = d_key;
`endif
  assign spacePressed = sp_key;

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receive-only PS/2 keyboard front end for the shooter top level. It samples the keyboard clock and data lines, deframes 11-bit device-to-host frames and decodes scan-code set 2 make/break sequences. It drives the held-key levels `aPressed`, `dPressed` and `spacePressed` consumed by `playerMovementFSM` and the fire logic, plus a raw byte strobe for debug.

## Interface
- `FILTER_LEN`, 8: consecutive identical synchronized samples before the filtered PS/2 clock changes; range 2–31.
- `TIMEOUT_CYCLES`, 100000: idle `clk` cycles inside a frame before it is aborted (2 ms at 50 MHz); 17-bit counter.
- `clk` input 1: system clock, `CLOCK_50`.
- `resetn` input 1: asynchronous, active-low reset (`KEY[0]`).
- `ps2_clk` input 1: raw keyboard clock pin.
- `ps2_dat` input 1: raw keyboard data pin.
- `aPressed` output 1: A (0x1C) currently held.
- `dPressed` output 1: D (0x23) currently held.
- `spacePressed` output 1: Space (0x29) currently held.
- `scan_code` output 8: last good byte received.
- `scan_valid` output 1: one-cycle pulse, `scan_code` updated.
- `frame_err` output 1: one-cycle pulse on parity or stop-bit error.

## Operation
- Both pins pass through 2-flop synchronizers. The clock path then feeds the glitch filter: the filtered clock takes the new level only after `FILTER_LEN` equal consecutive samples.
- Falling-edge strobe `fe` is high for one cycle when the filtered clock goes 1→0. Data is the synchronized `ps2_dat` value in the `fe` cycle.
- Deframer FSM:
  - IDLE: on `fe` with data=0 → DATA, bit count=0. On `fe` with data=1 → stay (false start).
  - DATA: shift in 8 bits, LSB first, on each `fe`. After the 8th bit → PARITY.
  - PARITY: on `fe`, latch the parity bit → STOP.
  - STOP: on `fe`:
    - stop=1 and odd parity over 8 data bits + parity bit correct: byte good, pulse `scan_valid`.
    - Otherwise: pulse `frame_err`, byte discarded.
    - Either way → IDLE.
- Timeout: in any state other than IDLE, the counter increments each cycle with no `fe` and resets on `fe`. On reaching `TIMEOUT_CYCLES` → IDLE, partial byte discarded, no `frame_err`.
- Decoder (acts only on good bytes), with `brk` and `ext` flags:
  - 0xF0: set `brk`.
  - 0xE0: set `ext`.
  - Any other byte with `ext`=0: matching key level ← ~`brk`. Unmapped codes are ignored.
  - Any other byte with `ext`=1: see Configuration.
  - After any non-prefix byte, clear `brk` and `ext`.
- Typematic repeats of a held key re-write 1; no effect.
- Key levels are independent. A and D can both be 1; arbitration belongs to the consumer.

## Timing
- Reset values: all outputs 0, FSM IDLE, flags clear, filter state 1 (bus idle), counters 0.
- Reset mid-frame aborts the frame immediately; held-key levels drop to 0.
- `scan_valid`/`frame_err` assert in the cycle after the stop-bit `fe`. Key levels change in that same cycle.
- Pin-to-output latency from the stop-bit falling edge is at most `FILTER_LEN`+4 cycles.
- `fe` and timeout expiry in the same cycle: `fe` wins, counter clears, frame continues.
- A new start bit may arrive in the cycle after STOP; no dead time.
- `scan_valid` and `frame_err` are never high together.

## Configuration
- `PS2_ARROWS_EN` defined:
  - E0 6B (left arrow) drives `aPressed`; E0 74 (right arrow) drives `dPressed`. Each arrow has its own held flag, OR'd with the letter flag.
  - E0 F0 6B / E0 F0 74 clear the arrow flags; the prefixes may arrive in either E0/F0 order.
- `PS2_ARROWS_EN` undefined: every byte following E0 is ignored apart from flag clearing; no arrow state is built.

## Test plan
- Reset, then frame 0x1C (parity 0, stop 1) → `scan_valid` pulse, `scan_code`=0x1C, `aPressed`=1; then F0,1C → `aPressed`=0, `scan_valid` pulsed twice.
- Send 0x23 then 0x29 → `dPressed`=1 and `spacePressed`=1 together; F0,23 → only `dPressed` drops.
- 0x1C frame with flipped parity bit → `frame_err` pulse, no `scan_valid`, `aPressed` stays 0. Same with stop=0.
- Stop the keyboard clock after 5 data bits for >100000 cycles, then send 0x23 → no error pulse, `dPressed`=1 (clean resync).
- 3-cycle low glitch on `ps2_clk` with `FILTER_LEN`=8 → no `fe`, state unchanged. Assert `resetn`=0 mid-frame while A is held → all outputs 0 asynchronously.
- With `PS2_ARROWS_EN`: E0,6B → `aPressed`=1; E0,F0,6B → 0. Without the macro, the same sequence leaves `aPressed`=0 and `scan_code`=0x6B.
